// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic tile engine.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } tile_state_e;

  // Zero-operand shift cycles needed to push the last skewed beat through an NxN array
  function automatic int unsigned flush_cycles(input int unsigned n);
    return 2 * n - 1;
  endfunction

  // Extend a dw-bit operand (held in the low bits of a) to 64 bits, signed or unsigned
  function automatic logic [63:0] ext64(input logic [31:0] a, input int unsigned dw, input bit sgn);
    logic [63:0] t;
    t = {32'd0, a} << (64 - dw);
    if (sgn) t = $signed(t) >>> (64 - dw);
    else     t = t >> (64 - dw);
    return t;
  endfunction

endpackage

// File: rtl/operand_skew.sv
// Enable-gated triangular delay line: lane l is delayed by l enabled cycles.
module operand_skew
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DATA_WIDTH*LANES-1:0]   din,
  output logic [DATA_WIDTH*LANES-1:0]   dout
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (l == 0) begin : g_pass
      assign dout[0 +: DATA_WIDTH] = din[0 +: DATA_WIDTH];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] pipe [l];

      // Shift this lane's delay chain on each enabled cycle
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int d = 0; d < l; d++) pipe[d] <= '0;
        end else if (en) begin
          pipe[0] <= din[l*DATA_WIDTH +: DATA_WIDTH];
          for (int d = 1; d < l; d++) pipe[d] <= pipe[d-1];
        end
      end

      assign dout[l*DATA_WIDTH +: DATA_WIDTH] = pipe[l-1];
    end
  end

endmodule

// File: rtl/systolic_array.sv
// NxN output-stationary systolic array: A flows right, B flows down, each PE accumulates a*b.
module systolic_array
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MATRIX_SIZE = 8,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter bit          SIGNED_MODE = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                acc_clr,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0]   left,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0]   top,
  output logic [ACC_WIDTH-1:0]                acc [MATRIX_SIZE*MATRIX_SIZE]
);

  localparam int unsigned N = MATRIX_SIZE;

  logic [DATA_WIDTH-1:0] a_q  [N][N];
  logic [DATA_WIDTH-1:0] b_q  [N][N];
  logic [DATA_WIDTH-1:0] a_in [N][N];
  logic [DATA_WIDTH-1:0] b_in [N][N];
  logic [ACC_WIDTH-1:0]  acc_q [N*N];

  // Operand routing: edge lanes feed row 0 / column 0, inner PEs take their neighbour's register
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = left[i*DATA_WIDTH +: DATA_WIDTH];
      b_in[0][i] = top[i*DATA_WIDTH +: DATA_WIDTH];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_q[i][j-1];
        b_in[j][i] = b_q[j-1][i];
      end
    end
  end

  // PE registers: pass operands on and multiply-accumulate (wrapping) on enable
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j]     <= '0;
          b_q[i][j]     <= '0;
          acc_q[i*N+j]  <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (en) begin
            a_q[i][j] <= a_in[i][j];
            b_q[i][j] <= b_in[i][j];
          end
          if (acc_clr) begin
            acc_q[i*N+j] <= '0;
          end else if (en) begin
            acc_q[i*N+j] <= acc_q[i*N+j] + ACC_WIDTH'(
              ext64(32'(a_in[i][j]), DATA_WIDTH, SIGNED_MODE) *
              ext64(32'(b_in[i][j]), DATA_WIDTH, SIGNED_MODE));
          end
        end
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/systolic_tile_engine.sv
// Self-sequencing C = A*B (+C) tile engine: feed K beats, flush, drain N*N results.
module systolic_tile_engine
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MATRIX_SIZE    = 8,
  parameter int unsigned ACC_WIDTH      = 32,
  parameter int unsigned MAX_K          = 256,
  parameter int unsigned K_WIDTH        = $clog2(MAX_K + 1),
  parameter int unsigned ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE * MATRIX_SIZE),
  parameter bit          SIGNED_MODE    = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [K_WIDTH-1:0]                  k_len,
  input  logic                                accumulate,
  output logic                                busy,
  output logic                                done,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0]   in_left,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0]   in_top,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ACC_WIDTH-1:0]                out_data,
  output logic [ACC_ADDR_WIDTH-1:0]           out_idx,
  output logic                                out_last
);

  localparam int unsigned N        = MATRIX_SIZE;
  localparam int unsigned NN       = N * N;
  localparam int unsigned FLUSH_N  = flush_cycles(N);
  localparam int unsigned FLUSH_W  = $clog2(FLUSH_N + 1);

  tile_state_e                        state;
  logic [K_WIDTH-1:0]                 k_q;
  logic [K_WIDTH-1:0]                 k_cnt;
  logic [FLUSH_W-1:0]                 flush_cnt;
  logic                               clr_q;

  logic                               en_c;
  logic                               acc_clr_c;
  logic [K_WIDTH-1:0]                 k_eff_c;
  logic [ACC_ADDR_WIDTH-1:0]          nidx_c;
  logic [DATA_WIDTH*N-1:0]            left_in_c;
  logic [DATA_WIDTH*N-1:0]            top_in_c;
  logic [DATA_WIDTH*N-1:0]            left_sk;
  logic [DATA_WIDTH*N-1:0]            top_sk;
  logic [ACC_WIDTH-1:0]               acc [NN];

  // Pipeline enable, accumulator clear, operand gating and drain index arithmetic
  always_comb begin
    en_c      = ((state == FEED) && in_valid && in_ready) || (state == FLUSH);
    acc_clr_c = (state == CLEAR) && clr_q;
    k_eff_c   = (k_len > K_WIDTH'(MAX_K)) ? K_WIDTH'(MAX_K) : k_len;
    nidx_c    = out_idx + ACC_ADDR_WIDTH'(1);
    left_in_c = (state == FEED) ? in_left : '0;
    top_in_c  = (state == FEED) ? in_top  : '0;
  end

  operand_skew #(.DATA_WIDTH(DATA_WIDTH), .LANES(N)) u_skew_left (
    .clk (clk), .rst (rst), .en (en_c), .din (left_in_c), .dout (left_sk)
  );

  operand_skew #(.DATA_WIDTH(DATA_WIDTH), .LANES(N)) u_skew_top (
    .clk (clk), .rst (rst), .en (en_c), .din (top_in_c), .dout (top_sk)
  );

  systolic_array #(
    .DATA_WIDTH (DATA_WIDTH), .MATRIX_SIZE (N), .ACC_WIDTH (ACC_WIDTH), .SIGNED_MODE (SIGNED_MODE)
  ) u_array (
    .clk (clk), .rst (rst), .en (en_c), .acc_clr (acc_clr_c),
    .left (left_sk), .top (top_sk), .acc (acc)
  );

  // Command sequencer with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_q       <= '0;
      k_cnt     <= '0;
      flush_cnt <= '0;
      clr_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            busy  <= 1'b1;
            k_q   <= k_eff_c;
            k_cnt <= '0;
            clr_q <= !accumulate;
          end
        end
        CLEAR: begin
          if (k_q != '0) begin
            state    <= FEED;
            in_ready <= 1'b1;
          end else begin
            // Accumulators clear on this same edge, so present zero directly when clearing
            state     <= DRAIN;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_data  <= clr_q ? '0 : acc[0];
            out_last  <= (NN == 1);
          end
        end
        FEED: begin
          if (in_valid && in_ready) begin
            k_cnt <= k_cnt + K_WIDTH'(1);
            if (k_cnt == k_q - K_WIDTH'(1)) begin
              state     <= FLUSH;
              in_ready  <= 1'b0;
              flush_cnt <= '0;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_W'(FLUSH_N - 1)) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_data  <= acc[0];
            out_last  <= (NN == 1);
          end else begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_idx  <= nidx_c;
              out_data <= acc[nidx_c];
              out_last <= (nidx_c == ACC_ADDR_WIDTH'(NN - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Directed bench for systolic_tile_engine: 4x4 32-bit instance plus a 2x2 16-bit signed instance.
module tb_systolic_tile_engine;

  logic        clk;
  logic        rst;

  // 4x4, 8-bit operands, 32-bit accumulators
  logic        start, accumulate, busy, done, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [8:0]  k_len;
  logic [31:0] in_left, in_top, out_data;
  logic [3:0]  out_idx;

  // 2x2, 8-bit signed operands, 16-bit accumulators
  logic        start2, accumulate2, busy2, done2, in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
  logic [8:0]  k_len2;
  logic [15:0] in_left2, in_top2, out_data2;
  logic [1:0]  out_idx2;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int accept_cyc = 0;
  logic [31:0] exp_c [16];
  logic [15:0] exp2  [4];

  systolic_tile_engine #(
    .DATA_WIDTH(8), .MATRIX_SIZE(4), .ACC_WIDTH(32), .MAX_K(256), .SIGNED_MODE(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .accumulate(accumulate),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_top(in_top), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  systolic_tile_engine #(
    .DATA_WIDTH(8), .MATRIX_SIZE(2), .ACC_WIDTH(16), .MAX_K(256), .SIGNED_MODE(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .k_len(k_len2), .accumulate(accumulate2),
    .busy(busy2), .done(done2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_left(in_left2), .in_top(in_top2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd1(input int k, input bit acc);
    start = 1'b1; k_len = 9'(k); accumulate = acc;
    tick;
    accept_cyc = cyc;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  // Beat b: A = identity column b, B row b = b*4+j+1; gaps gives in_valid pattern 1,0,0,1,...
  task automatic feed1(input int k, input bit gaps);
    int b = 0;
    int c = 0;
    bit fire;
    while (b < k && c < 500) begin
      in_valid = gaps ? (c % 3 == 0) : 1'b1;
      for (int i = 0; i < 4; i++) begin
        in_left[i*8 +: 8] = (i == b) ? 8'd1 : 8'd0;
        in_top[i*8 +: 8]  = 8'(b * 4 + i + 1);
      end
      fire = in_valid && in_ready;
      tick;
      if (fire) b++;
      c++;
    end
    in_valid = 1'b0;
    check("feed_beats", 64'(b), 64'(k));
  endtask

  task automatic drain1(input bit rand_ready, input bit chk_lat, input int lat, input bit poke);
    int n = 0;
    int guard = 0;
    bit first = 1'b1;
    bit prev_stall = 1'b0;
    logic [31:0] pd;
    logic [3:0]  pi;
    logic        pl;
    while (n < 16 && guard < 1000) begin
      if (out_valid && first) begin
        if (chk_lat) check("first_valid_cycle", 64'(cyc - accept_cyc + 1), 64'(lat));
        first = 1'b0;
      end
      if (prev_stall) begin
        check("stall_data", out_data, pd);
        check("stall_idx", out_idx, pi);
        check("stall_last", out_last, pl);
      end
      start = poke && out_valid && (n < 2);
      out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      if (out_valid && out_ready) begin
        check("out_data", out_data, exp_c[n]);
        check("out_idx", out_idx, 64'(n));
        check("out_last", out_last, (n == 15));
        n++;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data; pi = out_idx; pl = out_last;
      tick;
      guard++;
    end
    out_ready = 1'b0;
    start = 1'b0;
    check("drain_beats", 64'(n), 16);
    check("done_pulse", done, 1);
    check("busy_after_drain", busy, 0);
  endtask

  task automatic tile1(input bit acc, input bit gaps, input bit rand_ready, input bit chk_lat);
    int d0;
    d0 = done_cnt;
    cmd1(4, acc);
    feed1(4, gaps);
    drain1(rand_ready, chk_lat, 13, 1'b0);
    tick;
    check("done_once", 64'(done_cnt - d0), 1);
    check("done_cleared", done, 0);
  endtask

  task automatic run2(input int k, input logic [15:0] l, input logic [15:0] t);
    int b = 0;
    int c = 0;
    int n = 0;
    bit fire;
    start2 = 1'b1; k_len2 = 9'(k); accumulate2 = 1'b0;
    tick;
    start2 = 1'b0;
    in_left2 = l; in_top2 = t;
    while (b < k && c < 200) begin
      in_valid2 = 1'b1;
      fire = in_valid2 && in_ready2;
      tick;
      if (fire) b++;
      c++;
    end
    in_valid2 = 1'b0;
    c = 0;
    out_ready2 = 1'b1;
    while (n < 4 && c < 200) begin
      if (out_valid2) begin
        check("out2_data", out_data2, exp2[n]);
        check("out2_idx", out_idx2, 64'(n));
        check("out2_last", out_last2, (n == 3));
        n++;
      end
      tick;
      c++;
    end
    out_ready2 = 1'b0;
    check("drain2_beats", 64'(n), 4);
    check("done2_pulse", done2, 1);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 0; k_len = 0; accumulate = 0; in_valid = 0; out_ready = 0; in_left = 0; in_top = 0;
    start2 = 0; k_len2 = 0; accumulate2 = 0; in_valid2 = 0; out_ready2 = 0; in_left2 = 0; in_top2 = 0;
    repeat (3) tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_busy2", busy2, 0);
    rst = 1'b0;
    tick;

    // A = I, B[k][j] = 4k+j+1, clear first: C = B
    for (int n = 0; n < 16; n++) exp_c[n] = 32'(n + 1);
    tile1(1'b0, 1'b0, 1'b0, 1'b0);

    // Same tile accumulated on top: C = 2B, first result on cycle K+2N+1 = 13
    for (int n = 0; n < 16; n++) exp_c[n] = 32'(2 * (n + 1));
    tile1(1'b1, 1'b0, 1'b0, 1'b1);

    // Gappy input and random backpressure: same values and order as a clean run
    for (int n = 0; n < 16; n++) exp_c[n] = 32'(n + 1);
    tile1(1'b0, 1'b1, 1'b1, 1'b0);

    // K=0 with accumulate keeps prior C = B
    d0 = done_cnt;
    cmd1(0, 1'b1);
    drain1(1'b0, 1'b0, 0, 1'b0);
    tick;
    check("k0_acc_done_once", 64'(done_cnt - d0), 1);

    // K=0 clearing drains zeros; start pulsed during DRAIN is ignored
    for (int n = 0; n < 16; n++) exp_c[n] = 32'd0;
    d0 = done_cnt;
    cmd1(0, 1'b0);
    drain1(1'b0, 1'b0, 0, 1'b1);
    repeat (4) tick;
    check("k0_clr_done_once", 64'(done_cnt - d0), 1);
    check("no_restart_busy", busy, 0);

    // Reset after two FEED beats aborts without done; a fresh tile then yields exactly C = B
    d0 = done_cnt;
    cmd1(4, 1'b1);
    feed1(2, 1'b0);
    check("mid_feed_busy", busy, 1);
    rst = 1'b1;
    tick;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    rst = 1'b0;
    tick;
    check("abort_no_done", 64'(done_cnt - d0), 0);
    for (int n = 0; n < 16; n++) exp_c[n] = 32'(n + 1);
    tile1(1'b0, 1'b0, 1'b0, 1'b0);

    // Signed 2x2: A = [-128,-128]^T, B = [-128,127]
    exp2[0] = 16'h4000; exp2[1] = 16'hC080; exp2[2] = 16'h4000; exp2[3] = 16'hC080;
    run2(1, {8'h80, 8'h80}, {8'h7F, 8'h80});
    tick;

    // 3 x 127*127 = 48387 wraps in 16 bits to -17149
    for (int n = 0; n < 4; n++) exp2[n] = 16'hBD03;
    run2(3, {8'h7F, 8'h7F}, {8'h7F, 8'h7F});
    tick;
    check("busy2_idle", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
